// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP bubble, per-stage payload widths and
// the occupancy classification used by pr_elastic_stage.
package pipeline_pkg;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ALU_SEL_W  = 5;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned MEM_RD_W   = 4;
  localparam int unsigned MEM_WR_W   = 3;
  localparam int unsigned WB_SEL_W   = 2;
  localparam int unsigned BR_JMP_W   = 4;
  localparam int unsigned OP_SEL_W   = 2;

  localparam int unsigned IF_ID_W  = PC_W + INSTR_W;
  localparam int unsigned ID_EX_W  = PC_W + 3 * DATA_W + ALU_SEL_W + OP_SEL_W +
                                     REG_ADDR_W + MEM_RD_W + MEM_WR_W +
                                     WB_SEL_W + BR_JMP_W + 1;
  localparam int unsigned EX_MEM_W = PC_W + 2 * DATA_W + REG_ADDR_W +
                                     MEM_RD_W + MEM_WR_W + WB_SEL_W + 1;
  localparam int unsigned MEM_WB_W = PC_W + 2 * DATA_W + REG_ADDR_W +
                                     WB_SEL_W + 1;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

endpackage

// File: rtl/ptr_wrap_inc.sv
// Pointer increment wrapping at DEPTH-1 by explicit compare, so any
// (non-power-of-two) depth is supported.
module ptr_wrap_inc #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_next
);

  always_comb begin
    o_next = i_ptr + PTR_W'(1);
    if (i_ptr == PTR_W'(DEPTH - 1)) begin
      o_next = '0;
    end
  end

endmodule

// File: rtl/pr_elastic_stage.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready
// on both sides, synchronous flush, hold-stall and a bubble payload when empty.
module pr_elastic_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic                       HOLD,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [WIDTH-1:0]           IN_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [WIDTH-1:0]           OUT_DATA,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int unsigned COUNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [COUNT_W-1:0] r_count;

  logic [PTR_W-1:0]   w_rd_next;
  logic [PTR_W-1:0]   w_wr_next;
  logic               w_push;
  logic               w_pop;
  occ_e               w_occ;

  ptr_wrap_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_inc (
    .i_ptr  (r_rd_ptr),
    .o_next (w_rd_next)
  );

  ptr_wrap_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_inc (
    .i_ptr  (r_wr_ptr),
    .o_next (w_wr_next)
  );

  always_comb begin
    w_occ = OCC_PARTIAL;
    if (r_count == '0) begin
      w_occ = OCC_EMPTY;
    end else if (r_count == COUNT_W'(DEPTH)) begin
      w_occ = OCC_FULL;
    end
  end

  // Readiness depends only on occupancy and HOLD, never on OUT_READY.
  assign IN_READY  = !HOLD && (w_occ != OCC_FULL);
  assign OUT_VALID = !HOLD && (w_occ != OCC_EMPTY);
  assign OUT_DATA  = (w_occ == OCC_EMPTY) ? BUBBLE : r_mem[r_rd_ptr];
  assign COUNT     = r_count;

  assign w_push = IN_VALID && IN_READY;
  assign w_pop  = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (!HOLD) begin
      if (w_push) begin
        r_wr_ptr <= w_wr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + COUNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - COUNT_W'(1);
      end
    end
  end

  // Storage is not reset; only COUNT and pointers define validity.
  always_ff @(posedge CLK) begin
    if (!RESET && !FLUSH && w_push) begin
      r_mem[r_wr_ptr] <= IN_DATA;
    end
  end

endmodule
